mode_select_ctrl: RTL and testbench
===================================

// Module: mode_select_ctrl
// PURPOSE
//   Top-level operating-mode controller. Debounces the front-panel push buttons and runs the
//   power/mode state machine. Drives the one-hot enables of the mode blocks, including the
//   60 s countdown display block. Consumes that block's expiry pulse and returns to standby.
//   Sits directly upstream of the countdown and mode-display stages.
// PARAMETERS
//   DEB_CYCLES   2_000_000   cycles a raw button must stay stable before it is accepted (20 ms @100 MHz)
//   IDLE_CYCLES  1_000_000_000  cycles of no accepted press in STANDBY before auto power-off (10 s)
// PORTS
//   clk          in   1  100 MHz system clock
//   rst          in   1  asynchronous, active-high reset
//   btn_power    in   1  raw power button, active-high, asynchronous to clk
//   btn_mode1    in   1  raw mode-1 button
//   btn_mode2    in   1  raw mode-2 button
//   btn_mode3    in   1  raw mode-3 (timed) button
//   timer_done   in   1  countdown expiry from timer stage, level or pulse, sampled on clk
//   en_mode1     out  1  enable for mode-1 block
//   en_mode2     out  1  enable for mode-2 block
//   en_mode3     out  1  enable for countdown/timed block
//   timer_clr    out  1  one-cycle pulse restarting the countdown
//   state_code   out  3  current state encoding for LEDs: OFF=0, STBY=1, M1=2, M2=3, M3=4
// BEHAVIOUR
//   Reset:
//   - state=OFF; all outputs 0; m3_used=0; debouncers cleared to "released"; idle counter 0.
//   Input conditioning:
//   - Each btn_* passes a 2-flop synchronizer, then its own debounce counter.
//   - The debounced level changes only after the synced input differs from it for DEB_CYCLES consecutive cycles.
//   - Any bounce restarts that count.
//   - Press pulse p_* = 1 clk on the debounced 0->1 edge.
//   - Latency raw press -> state change = 2 + DEB_CYCLES + 1 cycles.
//   - A button held down produces exactly one pulse.
//   Priority:
//   - Multiple pulses in the same cycle resolve as power > mode3 > mode2 > mode1.
//   - Only the winning pulse acts.
//   FSM (registered state; outputs are a decode of state except timer_clr):
//   - OFF : p_power -> STBY. All else ignored.
//   - STBY: p_power -> OFF.
//   - STBY: p_mode1 -> M1; p_mode2 -> M2.
//   - STBY: p_mode3 -> M3 only if m3_used=0, else stay.
//   - STBY: idle counter reaches IDLE_CYCLES-1 with no pulse -> OFF.
//   - M1/M2: p_power -> OFF.
//   - M1/M2: p_mode1/p_mode2 -> M1/M2; pressing the active mode is a no-op.
//   - M1/M2: p_mode3 -> M3 if m3_used=0, else no-op.
//   - M3: p_power -> OFF (abort). Mode buttons ignored.
//   - M3: timer_done=1 -> STBY on the next clk.
//   - M3: if timer_done coincides with p_power, p_power wins (-> OFF).
//   Flags and counters:
//   - m3_used: set on entry to M3; cleared only on entry to OFF or reset. Mode 3 is once per power session.
//   - timer_clr: 1 in the same cycle en_mode3 first goes high (entry to M3), else 0.
//   - timer_done: ignored in every state except M3.
//   - Idle counter: runs only in STBY; clears on any accepted pulse and on leaving STBY.
//   - Idle counter saturates, no wrap. Width = clog2(IDLE_CYCLES).
//   Output decode:
//   - en_mode1 = (M1), en_mode2 = (M2), en_mode3 = (M3); never more than one high.
//   - state_code is registered alongside state.
//   Reset mid-operation:
//   - Any state -> OFF immediately (async); m3_used cleared.
//   - A button held through reset release gives no pulse until it is released and pressed again.
// TESTING (DEB_CYCLES=4, IDLE_CYCLES=50)
//   1 power press held 20 cycles with 3 bounces first -> single p_power; state_code 0->1; latency 7 cycles after last bounce.
//   2 STBY, press mode3 -> state_code=4, en_mode3=1, timer_clr high exactly 1 cycle.
//     Then pulse timer_done -> state_code=1, en_mode3=0.
//   3 After test 2, press mode3 again -> stays STBY. Power off/on, then mode3 -> M3 accepted.
//   4 M1 and simultaneous mode1+mode2+mode3 press (m3_used=0) -> M3; in M3 press mode1 -> no change.
//   5 STBY with no press -> OFF at exactly 50 cycles; a mode2 press at cycle 40 -> M2, no auto-off.
//   6 In M3 assert rst for 1 cycle -> all outputs 0 same cycle. timer_done while OFF -> no change.
//     timer_done + power same cycle in M3 -> OFF.

Source files
------------

// File: rtl/mode_select_ctrl.sv
`timescale 1ns/1ps
// mode_select_ctrl: operating-mode controller.
// Conditions the four raw front-panel buttons (synchronize, debounce, edge
// detect) and runs the power/mode state machine that drives the one-hot mode
// enables, the countdown restart pulse and the LED state code.
//
// Handshake: there is no valid/ready traffic in this block. Each press pulse
// is a single-cycle strobe that the FSM consumes in the cycle it is high.
// timer_done is a level or pulse that is only looked at while in M3.
// timer_clr is a single-cycle strobe raised on entry to M3.
module mode_select_ctrl #(
    parameter int DEB_CYCLES  = 2_000_000,
    parameter int IDLE_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_power,
    input  logic       btn_mode1,
    input  logic       btn_mode2,
    input  logic       btn_mode3,
    input  logic       timer_done,
    output logic       en_mode1,
    output logic       en_mode2,
    output logic       en_mode3,
    output logic       timer_clr,
    output logic [2:0] state_code
);

    localparam int NBTN = 4;
    localparam int DCW  = $clog2(DEB_CYCLES + 1);
    localparam int ICW  = $clog2(IDLE_CYCLES);

    localparam logic [DCW-1:0] DEB_MAX  = DCW'(DEB_CYCLES - 1);
    localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_CYCLES - 1);

    // Button index map inside the conditioning vectors.
    localparam int B_POWER = 0;
    localparam int B_MODE1 = 1;
    localparam int B_MODE2 = 2;
    localparam int B_MODE3 = 3;

    // Encodings double as the LED state code.
    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_STBY = 3'd1,
        S_M1   = 3'd2,
        S_M2   = 3'd3,
        S_M3   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q;
    logic [NBTN-1:0] sync2_q;
    logic [NBTN-1:0] deb_q;
    logic [NBTN-1:0] deb_d;
    logic [NBTN-1:0] armed_q;
    logic [NBTN-1:0] armed_d;
    logic [NBTN-1:0] press_q;
    logic [NBTN-1:0] press_d;
    logic [DCW-1:0]  cnt_q [NBTN];
    logic [DCW-1:0]  cnt_d [NBTN];
    logic [1:0]      vld_q;
    logic [1:0]      vld_d;
    logic            sync_vld;

    assign btn_raw = {btn_mode3, btn_mode2, btn_mode1, btn_power};

    // Two-flop synchronizers for the asynchronous raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce counters, arming and rising-edge detection for every button.
    // The synchronizer outputs are only trusted once two edges have passed
    // since reset; a button is armed only after it has been seen released,
    // so a button held through reset release never produces a press.
    always_comb begin
        vld_d    = (vld_q == 2'd2) ? vld_q : vld_q + 2'd1;
        sync_vld = (vld_q == 2'd2);
        for (int i = 0; i < NBTN; i++) begin
            deb_d[i]   = deb_q[i];
            cnt_d[i]   = '0;
            press_d[i] = 1'b0;
            armed_d[i] = armed_q[i] | (sync_vld & ~sync2_q[i] & ~deb_q[i]);
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    deb_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i] & armed_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DCW'(1);
                end
            end
        end
    end

    // Debounce state registers; debounced levels reset to released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q   <= '0;
            armed_q <= '0;
            press_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q   <= deb_d;
            armed_q <= armed_d;
            press_q <= press_d;
            vld_q   <= vld_d;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    logic p_power;
    logic p_mode1;
    logic p_mode2;
    logic p_mode3;

    assign p_power = press_q[B_POWER];
    assign p_mode1 = press_q[B_MODE1];
    assign p_mode2 = press_q[B_MODE2];
    assign p_mode3 = press_q[B_MODE3];

    // ------------------------------------------------------------------
    // Power/mode state machine
    // ------------------------------------------------------------------
    state_t          state_q;
    state_t          state_d;
    logic            m3_used_q;
    logic            m3_used_d;
    logic [ICW-1:0]  idle_q;
    logic [ICW-1:0]  idle_d;
    logic            timer_clr_q;
    logic            timer_clr_d;

    // Next-state logic. Pulse priority is power > mode3 > mode2 > mode1 and
    // only the winning pulse acts, so a refused mode3 masks lower buttons.
    always_comb begin
        state_d     = state_q;
        m3_used_d   = m3_used_q;
        idle_d      = '0;
        timer_clr_d = 1'b0;

        case (state_q)
            S_OFF: begin
                if (p_power) begin
                    state_d = S_STBY;
                end
            end
            S_STBY: begin
                if (p_power) begin
                    state_d = S_OFF;
                end else if (p_mode3) begin
                    if (!m3_used_q) begin
                        state_d = S_M3;
                    end
                end else if (p_mode2) begin
                    state_d = S_M2;
                end else if (p_mode1) begin
                    state_d = S_M1;
                end else if (idle_q == IDLE_MAX) begin
                    state_d = S_OFF;
                end else begin
                    // Increment is gated by the compare above, so the
                    // counter saturates at IDLE_MAX rather than wrapping.
                    idle_d = idle_q + ICW'(1);
                end
            end
            S_M1, S_M2: begin
                if (p_power) begin
                    state_d = S_OFF;
                end else if (p_mode3) begin
                    if (!m3_used_q) begin
                        state_d = S_M3;
                    end
                end else if (p_mode2) begin
                    state_d = S_M2;
                end else if (p_mode1) begin
                    state_d = S_M1;
                end
            end
            S_M3: begin
                if (p_power) begin
                    state_d = S_OFF;
                end else if (timer_done) begin
                    state_d = S_STBY;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        // Mode 3 may be entered once per power session.
        if ((state_d == S_M3) && (state_q != S_M3)) begin
            m3_used_d   = 1'b1;
            timer_clr_d = 1'b1;
        end
        if ((state_d == S_OFF) && (state_q != S_OFF)) begin
            m3_used_d = 1'b0;
        end
    end

    // State, session flag, idle counter and countdown restart strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_OFF;
            m3_used_q   <= 1'b0;
            idle_q      <= '0;
            timer_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m3_used_q   <= m3_used_d;
            idle_q      <= idle_d;
            timer_clr_q <= timer_clr_d;
        end
    end

    // Outputs are a decode of the registered state, so they clear together
    // with the asynchronous reset.
    assign en_mode1   = (state_q == S_M1);
    assign en_mode2   = (state_q == S_M2);
    assign en_mode3   = (state_q == S_M3);
    assign timer_clr  = timer_clr_q;
    assign state_code = state_q;

endmodule

// File: tb/tb_mode_select_ctrl.sv
`timescale 1ns/1ps
// Bench for mode_select_ctrl with short debounce and idle constants.
module tb_mode_select_ctrl;

    localparam int DEB  = 4;
    localparam int IDLE = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_power;
    logic       btn_mode1;
    logic       btn_mode2;
    logic       btn_mode3;
    logic       timer_done;
    logic       en_mode1;
    logic       en_mode2;
    logic       en_mode3;
    logic       timer_clr;
    logic [2:0] state_code;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q[$];
    logic [6:0] obs;

    typedef struct packed {
        logic [3:0] mask;   // {mode3, mode2, mode1, power}
        logic       tpulse;
        logic [2:0] code;
    } step_t;

    step_t steps [0:22];

    mode_select_ctrl #(
        .DEB_CYCLES (DEB),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_power (btn_power),
        .btn_mode1 (btn_mode1),
        .btn_mode2 (btn_mode2),
        .btn_mode3 (btn_mode3),
        .timer_done(timer_done),
        .en_mode1  (en_mode1),
        .en_mode2  (en_mode2),
        .en_mode3  (en_mode3),
        .timer_clr (timer_clr),
        .state_code(state_code)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget, got no summary, required finish");
        $fatal(1);
    end

    assign obs = {state_code, en_mode3, en_mode2, en_mode1, timer_clr};

    // Expected output vector from the state code: one-hot enables decoded per mode.
    function automatic logic [6:0] exp_vec(input logic [2:0] code, input logic clr);
        return {code, (code == 3'd4), (code == 3'd3), (code == 3'd2), clr};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] mask);
        {btn_mode3, btn_mode2, btn_mode1, btn_power} = mask;
    endtask

    task automatic push_exp(input logic [2:0] code, input logic clr);
        exp_q.push_back(exp_vec(code, clr));
    endtask

    // Scoreboard: pop the oldest expectation and compare with the DUT.
    task automatic check_out(input string name);
        logic [6:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued, got %b", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: got code=%0d en3..1=%b clr=%b, required code=%0d en3..1=%b clr=%b",
                         name, obs[6:4], obs[3:1], obs[0], e[6:4], e[3:1], e[0]);
            end
        end
    endtask

    // One table step: press (with random hold), and/or a timer pulse, then compare.
    task automatic run_step(input int idx);
        int hold;
        push_exp(steps[idx].code, 1'b0);
        if (steps[idx].mask != 4'b0000) begin
            hold = $urandom_range(8, 14);
            set_btns(steps[idx].mask);
            tick(hold);
            set_btns(4'b0000);
            tick(8);
        end
        if (steps[idx].tpulse) begin
            timer_done = 1'b1;
            tick(1);
            timer_done = 1'b0;
            tick(2);
        end
        check_out($sformatf("step%0d", idx));
    endtask

    initial begin
        // Vector table: runs from STBY with mode 3 already used this session.
        steps[0]  = '{4'b1000, 1'b0, 3'd1};  // mode3 refused in STBY
        steps[1]  = '{4'b0001, 1'b0, 3'd0};  // power off
        steps[2]  = '{4'b0001, 1'b0, 3'd1};  // power on
        steps[3]  = '{4'b1000, 1'b0, 3'd4};  // mode3 allowed again
        steps[4]  = '{4'b0000, 1'b1, 3'd1};  // expiry -> STBY
        steps[5]  = '{4'b0001, 1'b0, 3'd0};
        steps[6]  = '{4'b0001, 1'b0, 3'd1};
        steps[7]  = '{4'b0010, 1'b0, 3'd2};  // M1
        steps[8]  = '{4'b0010, 1'b0, 3'd2};  // active mode no-op
        steps[9]  = '{4'b0100, 1'b0, 3'd3};  // M1 -> M2
        steps[10] = '{4'b0010, 1'b0, 3'd2};  // M2 -> M1
        steps[11] = '{4'b1110, 1'b0, 3'd4};  // simultaneous: mode3 wins
        steps[12] = '{4'b0010, 1'b0, 3'd4};  // mode buttons ignored in M3
        steps[13] = '{4'b0100, 1'b0, 3'd4};
        steps[14] = '{4'b0000, 1'b1, 3'd1};
        steps[15] = '{4'b0100, 1'b0, 3'd3};  // STBY -> M2
        steps[16] = '{4'b1000, 1'b0, 3'd3};  // mode3 used: no-op
        steps[17] = '{4'b0000, 1'b1, 3'd3};  // timer_done ignored in M2
        steps[18] = '{4'b0011, 1'b0, 3'd0};  // power beats mode1
        steps[19] = '{4'b0000, 1'b1, 3'd0};  // timer_done ignored in OFF
        steps[20] = '{4'b0010, 1'b0, 3'd0};  // mode ignored in OFF
        steps[21] = '{4'b0001, 1'b0, 3'd1};
        steps[22] = '{4'b0001, 1'b0, 3'd0};

        // Reset
        rst        = 1'b1;
        timer_done = 1'b0;
        set_btns(4'b0000);
        tick(3);
        push_exp(3'd0, 1'b0);
        check_out("reset");
        rst = 1'b0;
        tick(2);

        // Bouncy power press: three bounces, then held 20 cycles.
        for (int k = 0; k < 3; k++) begin
            btn_power = 1'b1;
            tick(1);
            btn_power = 1'b0;
            tick(1);
        end
        btn_power = 1'b1;
        push_exp(3'd0, 1'b0);
        tick(6);
        check_out("t1_before_latency");
        push_exp(3'd1, 1'b0);
        tick(1);
        check_out("t1_latency7");
        tick(13);
        push_exp(3'd1, 1'b0);
        check_out("t1_single_pulse_held");
        btn_power = 1'b0;
        tick(10);
        push_exp(3'd1, 1'b0);
        check_out("t1_after_release");

        // Mode 3 entry with cycle-exact timer_clr, then expiry.
        btn_mode3 = 1'b1;
        push_exp(3'd1, 1'b0);
        tick(6);
        check_out("t2_pre_entry");
        push_exp(3'd4, 1'b1);
        tick(1);
        check_out("t2_entry_clr");
        push_exp(3'd4, 1'b0);
        tick(1);
        check_out("t2_clr_one_cycle");
        tick(8);
        btn_mode3 = 1'b0;
        tick(8);
        timer_done = 1'b1;
        push_exp(3'd1, 1'b0);
        tick(1);
        check_out("t2_expiry_stby");
        timer_done = 1'b0;
        tick(2);

        // Table-driven vectors.
        for (int i = 0; i <= 22; i++) begin
            run_step(i);
        end

        // Auto power-off exactly IDLE cycles after entering STBY.
        btn_power = 1'b1;
        tick(10);
        btn_power = 1'b0;
        tick(46);
        push_exp(3'd1, 1'b0);
        check_out("t5_idle_49");
        push_exp(3'd0, 1'b0);
        tick(1);
        check_out("t5_idle_off_50");

        // Mode2 press pulse at STBY cycle 40 prevents auto-off.
        btn_power = 1'b1;
        tick(10);
        btn_power = 1'b0;
        tick(30);
        btn_mode2 = 1'b1;
        push_exp(3'd1, 1'b0);
        tick(6);
        check_out("t5_stby_c39");
        push_exp(3'd3, 1'b0);
        tick(1);
        check_out("t5_m2_c40");
        tick(3);
        btn_mode2 = 1'b0;
        push_exp(3'd3, 1'b0);
        tick(10);
        check_out("t5_no_autooff");

        // Asynchronous reset from M3 with power held through reset release.
        steps[0] = '{4'b1000, 1'b0, 3'd4};
        run_step(0);
        rst = 1'b1;
        #2;
        push_exp(3'd0, 1'b0);
        check_out("t6_async_reset");
        btn_power = 1'b1;
        tick(1);
        tick(1);
        rst = 1'b0;
        tick(20);
        push_exp(3'd0, 1'b0);
        check_out("t6_held_through_reset");
        btn_power = 1'b0;
        tick(10);
        steps[1] = '{4'b0001, 1'b0, 3'd1};
        run_step(1);
        steps[2] = '{4'b1000, 1'b0, 3'd4};  // m3_used cleared by reset
        run_step(2);

        // timer_done coinciding with the power pulse in M3: power wins.
        btn_power = 1'b1;
        tick(6);
        timer_done = 1'b1;
        push_exp(3'd0, 1'b0);
        tick(1);
        check_out("t6_done_vs_power");
        timer_done = 1'b0;
        tick(4);
        btn_power = 1'b0;
        tick(8);
        timer_done = 1'b1;
        tick(2);
        timer_done = 1'b0;
        push_exp(3'd0, 1'b0);
        tick(1);
        check_out("t6_done_in_off");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
